// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu_pkg
//  Purpose  : Shared encodings for the memory-stage load/store unit.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int c_DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_align
//  Purpose  : Byte-lane steering for stores and extract/extend for loads.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_ld_offset,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_sign_ext,
    input  logic [31:0] i_rdata,
    output logic [1:0]  o_offset,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Misaligned halves/words are forced onto their natural lane here.
    always_comb begin
        o_offset    = 2'b00;
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_offset    = i_addr_lo;
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_offset    = {i_addr_lo[1], 1'b0};
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
            end
            default: begin
                o_offset    = 2'b00;
                o_be        = 4'b1111;
                o_wdata_rep = i_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_ld_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_ld_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{i_ld_sign_ext & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{i_ld_sign_ext & w_half[15]}}, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : MEM-stage load/store unit with req/ack data-memory handshake.
//             Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rdata_out,
    output logic        load_done,
    output logic        bus_err,
    output logic        misalign
);

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_sign_ext;
    logic        r_err;

    logic        w_start;
    logic        w_trap;
    logic [1:0]  w_offset;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_ld_data;

    assign w_start = valid_in & (mem_read | mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        case (size)
            SZ_BYTE: w_trap = 1'b0;
            SZ_HALF: w_trap = addr[0];
            default: w_trap = |addr[1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (r_state == ST_IDLE) & w_start & w_trap;
        end
    end
`else
    assign w_trap   = 1'b0;
    assign misalign = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .i_addr_lo     (addr[1:0]),
        .i_size        (size),
        .i_wdata       (wdata),
        .i_ld_offset   (r_offset),
        .i_ld_size     (r_size),
        .i_ld_sign_ext (r_sign_ext),
        .i_rdata       (dmem_rdata),
        .o_offset      (w_offset),
        .o_be          (w_be),
        .o_wdata_rep   (w_wdata_rep),
        .o_ld_data     (w_ld_data)
    );

    assign stall     = (r_state == ST_WAIT) | ((r_state == ST_IDLE) & w_start & ~w_trap);
    assign dmem_req  = (r_state == ST_WAIT);
    assign load_done = (r_state == ST_DONE) & ~r_err;
    assign bus_err   = (r_state == ST_DONE) & r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_offset   <= 2'b00;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_err      <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            rdata_out  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_trap) begin
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_we    <= mem_write;
                        dmem_be    <= w_be;
                        dmem_wdata <= w_wdata_rep;
                        r_offset   <= w_offset;
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_cnt      <= 8'd0;
                        r_err      <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            rdata_out <= w_ld_data;
                        end
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        rdata_out <= 32'd0;
                        r_err     <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_lsu
//  Purpose  : Directed scoreboard bench for mem_lsu (TIMEOUT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] rdata_out;
    logic        load_done;
    logic        bus_err;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] sb[$];

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .rdata_out  (rdata_out),
        .load_done  (load_done),
        .bus_err    (bus_err),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // waits < 0 means the memory never acknowledges.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int waits,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input int exp_stall,
                              input logic exp_err, input logic [31:0] exp_res);
        int          stall_cnt;
        int          wait_cnt;
        bit          done;
        bit          first;
        logic [32:0] exp_item;
        stall_cnt = 0;
        wait_cnt  = 0;
        done      = 1'b0;
        first     = 1'b1;
        sb.push_back({exp_err, exp_res});
        valid_in  = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        size      = sz;
        sign_ext  = sx;
        addr      = a;
        wdata     = wd;
        #1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (stall) stall_cnt++;
            if (dmem_req) begin
                if (first) begin
                    first = 1'b0;
                    check({tag, " addr"}, dmem_addr, exp_addr);
                    check({tag, " be"}, {28'd0, dmem_be}, {28'd0, exp_be});
                    check({tag, " we"}, {31'd0, dmem_we}, {31'd0, wr});
                    if (wr) check({tag, " wdata"}, dmem_wdata, exp_wd);
                end
                dmem_ack   = (waits >= 0) && (wait_cnt == waits);
                dmem_rdata = dmem_ack ? rdat : 32'd0;
                wait_cnt++;
            end else begin
                dmem_ack = 1'b0;
            end
            tick();
            if (load_done || bus_err) done = 1'b1;
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        valid_in   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        check({tag, " completed"}, {31'd0, done}, 32'd1);
        check({tag, " stall cycles"}, stall_cnt, exp_stall);
        check({tag, " stall in done"}, {31'd0, stall}, 32'd0);
        exp_item = sb.pop_front();
        check({tag, " bus_err"}, {31'd0, bus_err}, {31'd0, exp_item[32]});
        check({tag, " load_done"}, {31'd0, load_done}, {31'd0, ~exp_item[32]});
        check({tag, " rdata_out"}, rdata_out, exp_item[31:0]);
        tick();
        check({tag, " pulse end"}, {30'd0, load_done, bus_err}, 32'd0);
        check({tag, " idle req"}, {30'd0, dmem_req, stall}, 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        valid_in   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        size       = 2'b00;
        sign_ext   = 1'b0;
        addr       = 32'd0;
        wdata      = 32'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        repeat (3) tick();
        rst = 1'b1;
        #1;

        check("reset ctrl", {27'd0, stall, dmem_req, load_done, bus_err, misalign}, 32'd0);
        check("reset rdata_out", rdata_out, 32'd0);
        check("reset dmem_addr", dmem_addr, 32'd0);
        check("reset dmem_be", {28'd0, dmem_be}, 32'd0);

        run_access("word store", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF,
                   32'd0, 0, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 2, 1'b0, 32'd0);
        run_access("sbyte load", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'd0,
                   32'h8011_2233, 0, 32'h0000_2000, 4'b1000, 32'd0, 2, 1'b0, 32'hFFFF_FF80);
        run_access("ubyte load", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'd0,
                   32'h8011_2233, 0, 32'h0000_2000, 4'b1000, 32'd0, 2, 1'b0, 32'h0000_0080);
        run_access("half load 3ws", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'd0,
                   32'hABCD_0000, 3, 32'h0000_0010, 4'b1100, 32'd0, 5, 1'b0, 32'h0000_ABCD);
        run_access("byte store", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'h0000_00A5,
                   32'd0, 1, 32'h0000_0030, 4'b0010, 32'hA5A5_A5A5, 3, 1'b0, 32'h0000_ABCD);
        run_access("half store", 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h5555_1234,
                   32'd0, 0, 32'h0000_0040, 4'b1100, 32'h1234_1234, 2, 1'b0, 32'h0000_ABCD);
        run_access("shalf load", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'd0,
                   32'h7777_8001, 0, 32'h0000_0100, 4'b0011, 32'd0, 2, 1'b0, 32'hFFFF_8001);

        // Reset while WAIT is outstanding; a late ack must not complete anything.
        valid_in = 1'b1;
        mem_read = 1'b1;
        size     = 2'b10;
        addr     = 32'h0000_4000;
        tick();
        check("rst-wait req", {31'd0, dmem_req}, 32'd1);
        rst      = 1'b0;
        valid_in = 1'b0;
        mem_read = 1'b0;
        tick();
        rst = 1'b1;
        check("rst-wait ctrl", {30'd0, dmem_req, stall}, 32'd0);
        check("rst-wait rdata", rdata_out, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        check("late ack", {29'd0, load_done, bus_err, dmem_req}, 32'd0);
        check("late ack rdata", rdata_out, 32'd0);

        run_access("fill", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'd0,
                   32'hCAFE_F00D, 0, 32'h0000_0200, 4'b1111, 32'd0, 2, 1'b0, 32'hCAFE_F00D);
        run_access("timeout", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'd0,
                   32'd0, -1, 32'h0000_3000, 4'b1111, 32'd0, 5, 1'b1, 32'd0);

        // Slots that must not start an access.
        valid_in = 1'b0;
        mem_read = 1'b1;
        #1;
        check("invalid slot stall", {31'd0, stall}, 32'd0);
        tick();
        check("invalid slot req", {31'd0, dmem_req}, 32'd0);
        valid_in = 1'b1;
        mem_read = 1'b0;
        #1;
        check("non-mem stall", {31'd0, stall}, 32'd0);
        tick();
        check("non-mem req", {31'd0, dmem_req}, 32'd0);
        valid_in = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
        valid_in = 1'b1;
        mem_read = 1'b1;
        size     = 2'b10;
        addr     = 32'h0000_1001;
        #1;
        check("misalign stall", {31'd0, stall}, 32'd0);
        tick();
        valid_in = 1'b0;
        mem_read = 1'b0;
        check("misalign pulse", {31'd0, misalign}, 32'd1);
        check("misalign req", {31'd0, dmem_req}, 32'd0);
        tick();
        check("misalign end", {30'd0, misalign, dmem_req}, 32'd0);
`else
        run_access("misalign word", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'd0,
                   32'h1234_5678, 0, 32'h0000_1000, 4'b1111, 32'd0, 2, 1'b0, 32'h1234_5678);
        check("misalign tied", {31'd0, misalign}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
